// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - sprite/stage layer compositor with a 3-stage pixel pipeline (optional LAYER_COMPOSITOR_OVERLAP_EN overlap counter)
module layer_compositor #(
    parameter int NUM_SPR     = 4,
    parameter int SPR_SIZE    = 16,
    parameter int SCALE_SHIFT = 1,
    parameter int WIN_X0      = 56,
    parameter int WIN_W       = 208,
    parameter int WIN_H       = 240,
    localparam int SEL_W      = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
    localparam int SPR_LOG    = $clog2(SPR_SIZE),
    localparam int SA_W       = 4 + 2 * SPR_LOG
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic             blank,
    input  logic             frame_tick,
    input  logic             wr_req,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [8:0]       wr_x,
    input  logic [8:0]       wr_y,
    input  logic [3:0]       wr_tile,
    input  logic             wr_en,
    output logic             wr_ack,
    output logic [15:0]      stage_addr,
    input  logic [1:0]       stage_q,
    output logic [SA_W-1:0]  sprite_addr,
    input  logic [2:0]       sprite_q,
    output logic [3:0]       pix_index
`ifdef LAYER_COMPOSITOR_OVERLAP_EN
    ,
    output logic [15:0]      overlap_count
`endif
);

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [3:0] tile;
        logic       en;
    } spr_t;

    spr_t pend [NUM_SPR];
    spr_t act  [NUM_SPR];

    logic [9:0] sx;
    logic [9:0] xs;
    logic [9:0] ys;
    logic       in_win;

    logic [NUM_SPR-1:0] hits;
    logic               hit_any;
    logic [3:0]         sel_tile;
    logic [SPR_LOG-1:0] sel_dx;
    logic [SPR_LOG-1:0] sel_dy;

    logic s1_in_win;
    logic s1_hit;
    logic s2_in_win;
    logic s2_hit;

    assign sx     = DrawX >> SCALE_SHIFT;
    assign ys     = DrawY >> SCALE_SHIFT;
    assign xs     = sx - 10'(WIN_X0);
    assign in_win = blank && (sx >= 10'(WIN_X0)) && (sx < 10'(WIN_X0 + WIN_W)) && (ys < 10'(WIN_H));

    // Per-channel hit test on the active sets; scanning high to low leaves the lowest-index hit selected
    always_comb begin
        hits     = '0;
        hit_any  = 1'b0;
        sel_tile = '0;
        sel_dx   = '0;
        sel_dy   = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            hits[i] = act[i].en
                   && (xs >= {1'b0, act[i].x}) && (xs < ({1'b0, act[i].x} + 10'(SPR_SIZE)))
                   && (ys >= {1'b0, act[i].y}) && (ys < ({1'b0, act[i].y} + 10'(SPR_SIZE)));
            if (hits[i]) begin
                hit_any  = 1'b1;
                sel_tile = act[i].tile;
                sel_dx   = SPR_LOG'(xs - {1'b0, act[i].x});
                sel_dy   = SPR_LOG'(ys - {1'b0, act[i].y});
            end
        end
    end

    // Register-write handshake: ack every other cycle while requested; frame_tick latches the pre-write pending sets
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ack <= 1'b0;
            for (int i = 0; i < NUM_SPR; i++) begin
                pend[i] <= '0;
                act[i]  <= '0;
            end
        end else begin
            wr_ack <= wr_req && !wr_ack;
            if (frame_tick) begin
                for (int i = 0; i < NUM_SPR; i++) begin
                    act[i] <= pend[i];
                end
            end
            if (wr_req && !wr_ack) begin
                for (int i = 0; i < NUM_SPR; i++) begin
                    if (wr_sel == SEL_W'(i)) begin
                        pend[i] <= {wr_x, wr_y, wr_tile, wr_en};
                    end
                end
            end
        end
    end

    // S1 addresses, S2 flags aligned with the RAM read data, S3 final palette index
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_in_win   <= 1'b0;
            s1_hit      <= 1'b0;
            stage_addr  <= '0;
            sprite_addr <= '0;
            s2_in_win   <= 1'b0;
            s2_hit      <= 1'b0;
            pix_index   <= '0;
        end else begin
            s1_in_win   <= in_win;
            s1_hit      <= hit_any;
            stage_addr  <= in_win ? (16'(ys) * 16'(WIN_W) + 16'(xs)) : 16'd0;
            sprite_addr <= hit_any ? {sel_tile, sel_dy, sel_dx} : '0;
            s2_in_win   <= s1_in_win;
            s2_hit      <= s1_hit;
            if (!s2_in_win) begin
                pix_index <= 4'd0;
            end else if (s2_hit && (sprite_q != 3'd0)) begin
                pix_index <= {1'b1, sprite_q};
            end else begin
                pix_index <= {2'b00, stage_q};
            end
        end
    end

`ifdef LAYER_COMPOSITOR_OVERLAP_EN
    logic [3:0]  hit_cnt;
    logic [15:0] ovl_cnt;

    // Number of channels covering the current pixel
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            hit_cnt = hit_cnt + {3'b000, hits[i]};
        end
    end

    // Saturating overlap counter, published and cleared at each frame start
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ovl_cnt       <= '0;
            overlap_count <= '0;
        end else if (frame_tick) begin
            overlap_count <= ovl_cnt;
            ovl_cnt       <= '0;
        end else if (in_win && (hit_cnt >= 4'd2) && (ovl_cnt != 16'hFFFF)) begin
            ovl_cnt <= ovl_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - directed self-checking bench for layer_compositor
module tb_layer_compositor;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        frame_tick;
    logic        wr_req;
    logic [1:0]  wr_sel;
    logic [8:0]  wr_x;
    logic [8:0]  wr_y;
    logic [3:0]  wr_tile;
    logic        wr_en;
    logic        wr_ack;
    logic [15:0] stage_addr;
    logic [1:0]  stage_q;
    logic [11:0] sprite_addr;
    logic [2:0]  sprite_q;
    logic [3:0]  pix_index;
`ifdef LAYER_COMPOSITOR_OVERLAP_EN
    logic [15:0] overlap_count;
`endif

    int checks = 0;
    int errors = 0;
    int ack_cnt;

    layer_compositor dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .frame_tick  (frame_tick),
        .wr_req      (wr_req),
        .wr_sel      (wr_sel),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_tile     (wr_tile),
        .wr_en       (wr_en),
        .wr_ack      (wr_ack),
        .stage_addr  (stage_addr),
        .stage_q     (stage_q),
        .sprite_addr (sprite_addr),
        .sprite_q    (sprite_q),
        .pix_index   (pix_index)
`ifdef LAYER_COMPOSITOR_OVERLAP_EN
        ,
        .overlap_count (overlap_count)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input logic [9:0] x, input logic [9:0] y, input logic b);
        DrawX = x;
        DrawY = y;
        blank = b;
    endtask

    task automatic write_spr(input logic [1:0] sel, input logic [8:0] x, input logic [8:0] y,
                             input logic [3:0] tile, input logic en, input logic ft);
        wr_req     = 1'b1;
        wr_sel     = sel;
        wr_x       = x;
        wr_y       = y;
        wr_tile    = tile;
        wr_en      = en;
        frame_tick = ft;
        tick(1);
        check("wr_ack_pulse", 32'(wr_ack), 32'd1);
        wr_req     = 1'b0;
        frame_tick = 1'b0;
        tick(1);
        check("wr_ack_drop", 32'(wr_ack), 32'd0);
    endtask

    task automatic pulse_frame();
        frame_tick = 1'b1;
        tick(1);
        frame_tick = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0;
        wr_req = 1'b1; wr_sel = 2'd1; wr_x = 9'd0; wr_y = 9'd0; wr_tile = 4'd0; wr_en = 1'b1;
        stage_q = 2'd2; sprite_q = 3'd0;
        set_pix(10'd112, 10'd0, 1'b1);
        tick(3);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_pix", 32'(pix_index), 32'd0);
        check("rst_sprite_addr", 32'(sprite_addr), 32'd0);
        wr_req = 1'b0;
        Reset  = 1'b0;

        // First window pixel: stage address after 1 cycle, pixel after exactly 3
        tick(1);
        check("s1_stage_addr_origin", 32'(stage_addr), 32'd0);
        tick(1);
        check("latency_not_early", 32'(pix_index), 32'd0);
        tick(1);
        check("pix_from_stage", 32'(pix_index), 32'd2);
        set_pix(10'd114, 10'd2, 1'b1);
        tick(1);
        check("stage_addr_1_1", 32'(stage_addr), 32'd209);

        // Window boundaries
        set_pix(10'd100, 10'd0, 1'b1);
        tick(1);
        check("left_out_addr", 32'(stage_addr), 32'd0);
        tick(2);
        check("left_out_pix", 32'(pix_index), 32'd0);
        set_pix(10'd112, 10'd0, 1'b0);
        tick(3);
        check("blank_pix", 32'(pix_index), 32'd0);
        set_pix(10'd527, 10'd0, 1'b1);
        tick(1);
        check("right_edge_in", 32'(stage_addr), 32'd207);
        set_pix(10'd528, 10'd0, 1'b1);
        tick(1);
        check("right_edge_out", 32'(stage_addr), 32'd0);
        set_pix(10'd112, 10'd479, 1'b1);
        tick(1);
        check("bottom_edge_in", 32'(stage_addr), 32'd49712);
        set_pix(10'd112, 10'd480, 1'b1);
        tick(1);
        check("bottom_edge_out", 32'(stage_addr), 32'd0);

        // Pending write stays invisible until frame_tick
        write_spr(2'd1, 9'd10, 9'd20, 4'd3, 1'b1, 1'b0);
        stage_q = 2'd1; sprite_q = 3'd5;
        set_pix(10'd136, 10'd44, 1'b1);
        tick(1);
        check("pending_no_sprite", 32'(sprite_addr), 32'd0);
        check("stage_addr_12_22", 32'(stage_addr), 32'd4588);
        tick(2);
        check("pending_pix_stage", 32'(pix_index), 32'd1);
        pulse_frame();
        tick(1);
        check("active_sprite_addr", 32'(sprite_addr), 32'd802);
        tick(2);
        check("active_sprite_pix", 32'(pix_index), 32'd13);

        // Lowest channel wins; transparency falls through to stage
        write_spr(2'd0, 9'd5, 9'd15, 4'd0, 1'b1, 1'b0);
        pulse_frame();
        sprite_q = 3'd0;
        tick(1);
        check("prio_ch0_addr", 32'(sprite_addr), 32'd119);
        tick(2);
        check("transparent_pix", 32'(pix_index), 32'd1);
        sprite_q = 3'd6;
        tick(3);
        check("ch0_opaque_pix", 32'(pix_index), 32'd14);
        set_pix(10'd162, 10'd44, 1'b1);
        tick(1);
        check("ch1_last_col", 32'(sprite_addr), 32'd815);
        set_pix(10'd164, 10'd44, 1'b1);
        tick(1);
        check("ch1_past_edge", 32'(sprite_addr), 32'd0);

        // Write coinciding with frame_tick waits for the next tick
        write_spr(2'd2, 9'd0, 9'd0, 4'd1, 1'b1, 1'b1);
        set_pix(10'd112, 10'd0, 1'b1);
        tick(1);
        check("tick_write_deferred", 32'(sprite_addr), 32'd0);
        pulse_frame();
        tick(1);
        check("tick_write_applied", 32'(sprite_addr), 32'd256);

        // Held request: one ack per two cycles
        ack_cnt = 0;
        wr_req = 1'b1; wr_sel = 2'd3; wr_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (wr_ack) ack_cnt++;
        end
        wr_req = 1'b0;
        check("held_req_acks", 32'(ack_cnt), 32'd3);

        // Reset mid-pipeline flushes pixels and sprites
        stage_q = 2'd2; sprite_q = 3'd0;
        tick(3);
        check("pre_reset_pix", 32'(pix_index), 32'd2);
        Reset = 1'b1;
        tick(1);
        check("reset_pix_clear", 32'(pix_index), 32'd0);
        Reset = 1'b0;
        blank = 1'b0;
        tick(1);
        blank = 1'b1;
        tick(1);
        check("reset_sprites_cleared", 32'(sprite_addr), 32'd0);
        tick(1);
        check("post_reset_not_early", 32'(pix_index), 32'd0);
        tick(1);
        check("post_reset_pix", 32'(pix_index), 32'd2);

`ifdef LAYER_COMPOSITOR_OVERLAP_EN
        blank = 1'b0;
        write_spr(2'd0, 9'd0, 9'd0, 4'd0, 1'b1, 1'b0);
        write_spr(2'd1, 9'd0, 9'd0, 4'd0, 1'b1, 1'b0);
        pulse_frame();
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 32; x++) begin
                set_pix(10'(112 + x), 10'(y), 1'b1);
                tick(1);
            end
        end
        blank = 1'b0;
        pulse_frame();
        check("overlap_count", 32'(overlap_count), 32'd1024);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 Parameters SHALL be:
- NUM_SPR, default 4, number of sprite channels (1..8).
- SPR_SIZE, default 16, sprite edge in window pixels; must be a power of two.
- SCALE_SHIFT, default 1, right shift from screen coordinates to window coordinates.
- WIN_X0, default 56, window left edge in scaled X.
- WIN_W, default 208, window width.
- WIN_H, default 240, window height.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- DrawX  in  10  screen column.
- DrawY  in  10  screen row.
- blank  in  1  1 = active video.
- frame_tick  in  1  one-cycle pulse at frame start.
- wr_req  in  1  sprite register write request.
- wr_sel  in  max(1,clog2(NUM_SPR))  target channel.
- wr_x  in  9  sprite X in window coordinates.
- wr_y  in  9  sprite Y in window coordinates.
- wr_tile  in  4  sprite tile number.
- wr_en  in  1  sprite visible.
- wr_ack  out  1  write accepted.
- stage_addr  out  16  stage RAM address.
- stage_q  in  2  stage RAM data (1-cycle read latency).
- sprite_addr  out  4+2*log2(SPR_SIZE)  sprite RAM address.
- sprite_q  in  3  sprite RAM data (1-cycle read latency); 0 = transparent.
- pix_index  out  4  composited palette index.
- overlap_count  out  16  present only under the macro in REQ-017.

Function
REQ-003 xs SHALL equal (DrawX>>SCALE_SHIFT)-WIN_X0 and ys SHALL equal DrawY>>SCALE_SHIFT.
REQ-004 A pixel SHALL be in-window iff blank=1, WIN_X0 <= DrawX>>SCALE_SHIFT < WIN_X0+WIN_W, and ys < WIN_H.
REQ-005 Pipeline stage S1 SHALL register the following from the current DrawX/DrawY:
- in-window flag;
- stage_addr = ys*WIN_W+xs when in-window, else 0;
- per-channel hit = enabled AND spr_x <= xs < spr_x+SPR_SIZE AND spr_y <= ys < spr_y+SPR_SIZE, with sums computed at 10 bits so there is no wrap.
REQ-006 S1 SHALL select the lowest-index hit channel and drive sprite_addr = tile*SPR_SIZE^2 + (ys-spr_y)*SPR_SIZE + (xs-spr_x); with no hit, sprite_addr SHALL be 0.
REQ-007 S2 SHALL capture stage_q, sprite_q, the hit-valid flag and the in-window flag.
REQ-008 S3 SHALL register pix_index with priority:
- not in-window -> 0;
- else hit-valid and sprite_q != 0 -> {1, sprite_q};
- else {00, stage_q}.
REQ-009 Latency from DrawX/DrawY to pix_index SHALL be exactly 3 Clk cycles, fully pipelined at one pixel per cycle.
REQ-010 Each channel SHALL hold a pending set and an active set {x, y, tile, en}; only the active set SHALL affect rendering.
REQ-011 wr_ack SHALL pulse for exactly one cycle, in the cycle after a cycle where wr_req=1 and wr_ack=0; the pending set of wr_sel SHALL be written in that same cycle.
REQ-012 wr_req held high SHALL produce one ack every two cycles. A wr_sel >= NUM_SPR SHALL be acked and discarded.
REQ-013 On frame_tick, all pending sets SHALL be copied to the active sets. A write acked in the same cycle as frame_tick SHALL NOT be included in that copy; it takes effect at the next frame_tick.

Reset
REQ-014 While Reset=1 at a Clk edge, the block SHALL clear the following:
- all pending and active sets to 0 (all sprites disabled);
- wr_ack, stage_addr, sprite_addr, pix_index, overlap_count, and all pipeline valid flags to 0.
REQ-015 Reset asserted mid-pipeline SHALL discard in-flight pixels. pix_index SHALL remain 0 until 3 cycles after the first in-window pixel following reset release.
REQ-016 A write request pending during Reset SHALL NOT be acked; wr_req must be re-presented after release.

Configuration
REQ-017 With LAYER_COMPOSITOR_OVERLAP_EN defined, the block SHALL operate as follows:
- an internal 16-bit counter SHALL increment each in-window cycle in which two or more channels hit, saturating at 0xFFFF;
- on frame_tick, the counter value SHALL be copied to overlap_count and the counter SHALL be cleared.
REQ-018 Without LAYER_COMPOSITOR_OVERLAP_EN, the overlap_count port and the counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-019 Reset, no sprites written, DrawX=112, DrawY=0, stage_q=2 -> stage_addr=0 after 1 cycle; pix_index=2 after 3 cycles.
REQ-020 DrawX=100 (scaled 50 < 56) or blank=0 -> stage_addr=0, and pix_index=0 after 3 cycles.
REQ-021 Write ch1 {x=10, y=20, tile=3, en=1} with no frame_tick, then DrawX=136, DrawY=44 -> pix_index from stage. After a frame_tick, the same pixel with sprite_q=5 -> sprite_addr=802, pix_index=13.
REQ-022 ch0 and ch1 both cover xs=12, ys=22, with ch0 tile=0 -> sprite_addr uses ch0. With sprite_q=0 and stage_q=1 -> pix_index=1.
REQ-023 wr_req asserted in the same cycle as frame_tick -> wr_ack in the next cycle; the new values render only after the following frame_tick. wr_req held 6 cycles -> 3 acks.
REQ-024 Under LAYER_COMPOSITOR_OVERLAP_EN: two fully overlapping 16x16 enabled sprites, SCALE_SHIFT=1, one frame -> overlap_count=1024 after the next frame_tick (each window pixel spans 2 Clk × 2 rows).
